adapter_16_to_32: RTL

Receive-side counterpart of the 32→16 stream splitter: reassembles a 16-bit half-word stream back into 32-bit words. The upstream sends each 32-bit word as two strobed 16-bit halves: high half first, low half on the next cycle, with `num_16_rdy` high on both. The block sits between the SDRAM read-back path and the 32-bit stream checker. It tolerates bounded gaps between halves, drops orphaned halves, and counts words and alignment errors.

---
 rtl/adapter_16_to_32.sv | 128 ++++++++++++
 1 files changed

// File: rtl/adapter_16_to_32.sv
// adapter_16_to_32: reassembles a strobed 16-bit half-word stream into 32-bit words.
// Each word arrives high half first, low half on a later strobe. A high half left
// waiting longer than MAX_GAP idle cycles is discarded and counted as an error.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   stream_16   half-word data, sampled when num_16_rdy = 1
//   num_16_rdy  half-word strobe
//   err_clr     synchronous clear of err_cnt
//   stream_32   last assembled word {high, low}
//   num_32_rdy  one-cycle pulse: stream_32 is new this cycle
//   drop        one-cycle pulse: a held high half was discarded
//   word_cnt    words delivered, wraps
//   err_cnt     discarded halves, saturates at all-ones
module adapter_16_to_32 #(
  parameter int unsigned MAX_GAP = 0,
  parameter int unsigned GAP_W   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      stream_16,
  input  logic             num_16_rdy,
  input  logic             err_clr,
  output logic [31:0]      stream_32,
  output logic             num_32_rdy,
  output logic             drop,
  output logic [CNT_W-1:0] word_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [GAP_W-1:0] MaxGap = GAP_W'(MAX_GAP);
  localparam logic [ERR_W-1:0] ErrMax = '1;

  typedef enum logic [0:0] {StIdle, StHigh} state_e;

  state_e           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0]      stream_32_q, stream_32_d;
  logic             rdy_q, rdy_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] err_base;
  logic             complete;
  logic             timeout;

  // Pairing FSM
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    complete = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (num_16_rdy) begin
          hold_d  = stream_16;
          gap_d   = '0;
          state_d = StHigh;
        end
      end
      StHigh: begin
        // A strobe always completes the pair, even on the last allowed gap cycle.
        if (num_16_rdy) begin
          complete = 1'b1;
          state_d  = StIdle;
        end else if (gap_q >= MaxGap) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs and counters
  always_comb begin
    stream_32_d = stream_32_q;
    word_cnt_d  = word_cnt_q;
    rdy_d       = complete;
    drop_d      = timeout;
    if (complete) begin
      stream_32_d = {hold_q, stream_16};
      word_cnt_d  = word_cnt_q + CNT_W'(1);
    end
    // Clear takes effect first, so a coincident timeout leaves a count of one.
    err_base  = err_clr ? '0 : err_cnt_q;
    err_cnt_d = err_base;
    if (timeout && (err_base != ErrMax)) begin
      err_cnt_d = err_base + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      gap_q       <= '0;
      stream_32_q <= '0;
      rdy_q       <= 1'b0;
      drop_q      <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      stream_32_q <= stream_32_d;
      rdy_q       <= rdy_d;
      drop_q      <= drop_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign stream_32  = stream_32_q;
  assign num_32_rdy = rdy_q;
  assign drop       = drop_q;
  assign word_cnt   = word_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
